// File: rtl/id_stage.sv
// Instruction-decode stage: decodes one instruction per cycle, reads operands with
// write-back bypass, extends the immediate and registers the execute-stage payload.
module id_stage (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] inst_i,
    input  logic        inst_valid_i,
    input  logic        stall_i,
    input  logic        flush_i,
    output logic [4:0]  rf_ra_addr_o,
    output logic [4:0]  rf_rb_addr_o,
    input  logic [31:0] rf_ra_data_i,
    input  logic [31:0] rf_rb_data_i,
    input  logic        wb_we_i,
    input  logic [4:0]  wb_addr_i,
    input  logic [31:0] wb_data_i,
    output logic [31:0] rd_value_o,
    output logic [31:0] rs_value_o,
    output logic [31:0] imm_value_o,
    output logic        immf_o,
    output logic        ctrl_inte_o,
    output logic        ctrl_logic_o,
    output logic        ctrl_shift_o,
    output logic        ctrl_ld_o,
    output logic        ctrl_st_o,
    output logic        ctrl_br_o,
    output logic [1:0]  func_o,
    output logic [4:0]  rd_addr_o,
    output logic        valid_o,
    output logic        stall_o,
    output logic        illegal_o
);

    localparam int unsigned XLEN  = 32;
    localparam int unsigned RW    = 5;
    localparam int unsigned IMMW  = 16;
    localparam int unsigned FUNCW = 2;
    localparam int unsigned SHAMW = 5;

    typedef enum logic [2:0] {
        CLS_NOP   = 3'b000,
        CLS_INTE  = 3'b001,
        CLS_LOGIC = 3'b010,
        CLS_SHIFT = 3'b011,
        CLS_LD    = 3'b100,
        CLS_ST    = 3'b101,
        CLS_BR    = 3'b110,
        CLS_RSV   = 3'b111
    } cls_e;

    typedef struct packed {
        logic [XLEN-1:0]  rd_value;
        logic [XLEN-1:0]  rs_value;
        logic [XLEN-1:0]  imm_value;
        logic             immf;
        logic             ctrl_inte;
        logic             ctrl_logic;
        logic             ctrl_shift;
        logic             ctrl_ld;
        logic             ctrl_st;
        logic             ctrl_br;
        logic [FUNCW-1:0] func;
        logic [RW-1:0]    rd_addr;
        logic             valid;
        logic             illegal;
    } ex_payload_t;

    cls_e             cls_c;
    logic             immf_c;
    logic [FUNCW-1:0] func_c;
    logic [RW-1:0]    rd_c;
    logic [RW-1:0]    rs_c;
    logic [IMMW-1:0]  imm16_c;

    logic [XLEN-1:0]  ra_value_c;
    logic [XLEN-1:0]  rb_value_c;
    logic [XLEN-1:0]  imm_ext_c;
    logic             reg_class_c;
    logic             use_rd_c;
    logic             use_rs_c;
    logic             hazard_c;

    ex_payload_t      dec_c;
    ex_payload_t      out_d;
    ex_payload_t      out_q;

    // Field extraction
    assign cls_c   = cls_e'(inst_i[31:29]);
    assign immf_c  = inst_i[28];
    assign func_c  = inst_i[27:26];
    assign rd_c    = inst_i[25:21];
    assign rs_c    = inst_i[20:16];
    assign imm16_c = inst_i[15:0];

    assign rf_ra_addr_o = rd_c;
    assign rf_rb_addr_o = rs_c;

    // Operand read: r0 is hard zero, otherwise a same-cycle write-back wins over the array
    always_comb begin
        ra_value_c = rf_ra_data_i;
        if (rd_c == RW'(0)) begin
            ra_value_c = '0;
        end else if (wb_we_i && (wb_addr_i == rd_c)) begin
            ra_value_c = wb_data_i;
        end

        rb_value_c = rf_rb_data_i;
        if (rs_c == RW'(0)) begin
            rb_value_c = '0;
        end else if (wb_we_i && (wb_addr_i == rs_c)) begin
            rb_value_c = wb_data_i;
        end
    end

    // Immediate extension by class
    always_comb begin
        imm_ext_c = {{(XLEN-IMMW){imm16_c[IMMW-1]}}, imm16_c};
        case (cls_c)
            CLS_LOGIC: imm_ext_c = XLEN'(imm16_c);
            CLS_SHIFT: imm_ext_c = XLEN'(imm16_c[SHAMW-1:0]);
            default:   imm_ext_c = {{(XLEN-IMMW){imm16_c[IMMW-1]}}, imm16_c};
        endcase
    end

    // Source-register usage for the hazard check
    always_comb begin
        reg_class_c = (cls_c == CLS_INTE) || (cls_c == CLS_LOGIC) ||
                      (cls_c == CLS_SHIFT) || (cls_c == CLS_BR);
        use_rd_c    = reg_class_c || (cls_c == CLS_ST);
        use_rs_c    = (reg_class_c && !immf_c) || (cls_c == CLS_LD) || (cls_c == CLS_ST);
    end

    assign hazard_c = out_q.valid && out_q.ctrl_ld && (out_q.rd_addr != RW'(0)) &&
                      inst_valid_i &&
                      ((use_rd_c && (rd_c == out_q.rd_addr)) ||
                       (use_rs_c && (rs_c == out_q.rd_addr)));

    assign stall_o = stall_i || hazard_c;

    // Decoded payload; the reserved class becomes a bubble that flags illegal
    always_comb begin
        dec_c           = '0;
        dec_c.rd_value  = ra_value_c;
        dec_c.rs_value  = rb_value_c;
        dec_c.imm_value = imm_ext_c;
        dec_c.immf      = immf_c;
        dec_c.func      = func_c;
        dec_c.rd_addr   = rd_c;
        dec_c.valid     = 1'b1;
        case (cls_c)
            CLS_INTE:  dec_c.ctrl_inte  = 1'b1;
            CLS_LOGIC: dec_c.ctrl_logic = 1'b1;
            CLS_SHIFT: dec_c.ctrl_shift = 1'b1;
            CLS_LD:    dec_c.ctrl_ld    = 1'b1;
            CLS_ST:    dec_c.ctrl_st    = 1'b1;
            CLS_BR:    dec_c.ctrl_br    = 1'b1;
            CLS_RSV: begin
                dec_c         = '0;
                dec_c.illegal = 1'b1;
            end
            default: ;
        endcase
    end

    // Next-state: flush > stall > hazard/empty slot > normal load; illegal is a pulse
    always_comb begin
        out_d         = out_q;
        out_d.illegal = 1'b0;
        if (flush_i) begin
            out_d = '0;
        end else if (!stall_i) begin
            if (hazard_c || !inst_valid_i) begin
                out_d = '0;
            end else begin
                out_d = dec_c;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_q <= '0;
        end else begin
            out_q <= out_d;
        end
    end

    assign rd_value_o   = out_q.rd_value;
    assign rs_value_o   = out_q.rs_value;
    assign imm_value_o  = out_q.imm_value;
    assign immf_o       = out_q.immf;
    assign ctrl_inte_o  = out_q.ctrl_inte;
    assign ctrl_logic_o = out_q.ctrl_logic;
    assign ctrl_shift_o = out_q.ctrl_shift;
    assign ctrl_ld_o    = out_q.ctrl_ld;
    assign ctrl_st_o    = out_q.ctrl_st;
    assign ctrl_br_o    = out_q.ctrl_br;
    assign func_o       = out_q.func;
    assign rd_addr_o    = out_q.rd_addr;
    assign valid_o      = out_q.valid;
    assign illegal_o    = out_q.illegal;

endmodule
